// File: rtl/ast_byte_packer_pkg.sv
// Types and helpers for the Avalon-ST byte packer.
package ast_byte_packer_pkg;

    // Packet framing state of the byte stream.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } ast_pkt_state_t;

    // Width of the empty field for a given beat size.
    function automatic int ast_empty_w(input int symbols);
        if (symbols == 1) begin
            return 1;
        end else begin
            return $clog2(symbols);
        end
    endfunction

    // Lane that receives the byte at position fill within a beat.
    // order 1 puts the first byte in the top symbol (big-endian AST).
    function automatic int ast_lane(input int fill, input int symbols, input int order);
        if (order == 1) begin
            return symbols - 1 - fill;
        end else begin
            return fill;
        end
    endfunction

endpackage : ast_byte_packer_pkg

// File: rtl/bloom_filter_pkg.sv
// Shared bloom-filter datapath constants.
package bloom_filter_pkg;

    // Width of one stream symbol (byte).
    localparam int BYTE_W = 8;

endpackage : bloom_filter_pkg

// File: rtl/ast_out_fifo2.sv
// Two-entry beat buffer for the byte packer. The head entry is a register
// that drives the AST source outputs directly; the second entry only fills
// while the head is stalled. almost_full_o is registered and tells the
// byte side whether another beat can be pushed next cycle.
module ast_out_fifo2 #(
    parameter  int DATA_W  = 64,
    parameter  int EMPTY_W = 3,
    localparam int BEAT_W  = DATA_W + 2 + EMPTY_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [BEAT_W-1:0] push_beat_i,
    input  logic              pop_ready_i,
    output logic [BEAT_W-1:0] head_beat_o,
    output logic [1:0]        occupancy_o,
    output logic              almost_full_o
);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } ast_beat_t;

    ast_beat_t  head_r;
    ast_beat_t  tail_r;
    ast_beat_t  push_beat_s;
    logic [1:0] count_r;
    logic [1:0] count_next_s;
    logic       afull_r;
    logic       pop_s;

    assign push_beat_s = push_beat_i;
    assign pop_s       = (count_r != 2'd0) && pop_ready_i;

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_i, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Beat storage, occupancy and registered back-pressure flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
            // Hold the byte side off while in reset.
            afull_r <= 1'b1;
        end else begin
            case ({push_i, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= push_beat_s;
                    end else begin
                        tail_r <= push_beat_s;
                    end
                end
                2'b01: begin
                    head_r <= tail_r;
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        head_r <= tail_r;
                        tail_r <= push_beat_s;
                    end else begin
                        head_r <= push_beat_s;
                    end
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
            count_r <= count_next_s;
            afull_r <= (count_next_s >= 2'd2);
        end
    end

    assign head_beat_o   = head_r;
    assign occupancy_o   = count_r;
    assign almost_full_o = afull_r;

endmodule : ast_out_fifo2

// File: rtl/ast_byte_packer.sv
// Avalon-ST source packer: gathers a byte stream with a last-byte marker
// into AST_SOURCE_SYMBOLS-wide beats carrying sop/eop/empty, buffered in a
// two-entry FIFO that honours downstream back-pressure.
// Build option: AST_BYTE_PACKER_ZERO_PAD_EN zeroes unwritten lanes of the
// eop beat by clearing the assembly register on every beat completion.
module ast_byte_packer
    import bloom_filter_pkg::*;
    import ast_byte_packer_pkg::*;
#(
    parameter int AST_SOURCE_SYMBOLS = 8,
    parameter int AST_SOURCE_ORDER   = 1,
    parameter int AST_SOURCE_EMPTY_W = (AST_SOURCE_SYMBOLS == 1) ? 1 : $clog2(AST_SOURCE_SYMBOLS)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [BYTE_W-1:0]                  byte_data_i,
    input  logic                               byte_valid_i,
    input  logic                               byte_last_i,
    output logic                               byte_ready_o,
    output logic [AST_SOURCE_SYMBOLS*BYTE_W-1:0] ast_source_data_o,
    output logic                               ast_source_valid_o,
    input  logic                               ast_source_ready_i,
    output logic                               ast_source_startofpacket_o,
    output logic                               ast_source_endofpacket_o,
    output logic [AST_SOURCE_EMPTY_W-1:0]      ast_source_empty_o
);

    localparam int DATA_W = AST_SOURCE_SYMBOLS * BYTE_W;
    localparam int CNT_W  = AST_SOURCE_EMPTY_W;
    localparam int BEAT_W = DATA_W + 2 + AST_SOURCE_EMPTY_W;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(AST_SOURCE_SYMBOLS - 1);

    typedef struct packed {
        logic [DATA_W-1:0]             data;
        logic                          sop;
        logic                          eop;
        logic [AST_SOURCE_EMPTY_W-1:0] empty;
    } ast_beat_t;

    ast_pkt_state_t    state_r;
    logic [CNT_W-1:0]  fill_cnt_r;
    logic [DATA_W-1:0] asm_r;
    logic              beat_sop_r;

    logic              accept_s;
    logic              complete_s;
    logic [CNT_W-1:0]  lane_s;
    logic [DATA_W-1:0] asm_next_s;
    ast_beat_t         push_beat_s;
    ast_beat_t         head_beat_s;
    logic [BEAT_W-1:0] head_flat_s;
    logic [1:0]        occupancy_s;
    logic              afull_s;

    assign accept_s   = byte_valid_i && byte_ready_o;
    assign complete_s = accept_s && ((fill_cnt_r == LAST_LANE) || byte_last_i);
    assign lane_s     = CNT_W'(ast_lane(int'(fill_cnt_r), AST_SOURCE_SYMBOLS, AST_SOURCE_ORDER));

    // Assembly register with the incoming byte dropped into its lane.
    always_comb begin
        asm_next_s = asm_r;
        for (int i = 0; i < AST_SOURCE_SYMBOLS; i++) begin
            if (lane_s == CNT_W'(i)) begin
                asm_next_s[i*BYTE_W +: BYTE_W] = byte_data_i;
            end else begin
                asm_next_s[i*BYTE_W +: BYTE_W] = asm_r[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Beat handed to the buffer when the accepted byte completes it.
    always_comb begin
        push_beat_s      = '0;
        push_beat_s.data = asm_next_s;
        push_beat_s.eop  = byte_last_i;
        if (fill_cnt_r == '0) begin
            push_beat_s.sop = (state_r == IDLE);
        end else begin
            push_beat_s.sop = beat_sop_r;
        end
        if (byte_last_i) begin
            push_beat_s.empty = LAST_LANE - fill_cnt_r;
        end else begin
            push_beat_s.empty = '0;
        end
    end

    // Fill counter and assembly register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_cnt_r <= '0;
            asm_r      <= '0;
        end else if (accept_s) begin
            if (complete_s) begin
                fill_cnt_r <= '0;
`ifdef AST_BYTE_PACKER_ZERO_PAD_EN
                asm_r      <= '0;
`else
                asm_r      <= asm_next_s;
`endif
            end else begin
                fill_cnt_r <= fill_cnt_r + CNT_W'(1);
                asm_r      <= asm_next_s;
            end
        end else begin
            fill_cnt_r <= fill_cnt_r;
            asm_r      <= asm_r;
        end
    end

    // Packet framing FSM; also latches sop for the beat being assembled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            beat_sop_r <= 1'b0;
        end else if (accept_s) begin
            if (fill_cnt_r == '0) begin
                beat_sop_r <= (state_r == IDLE);
            end
            case (state_r)
                IDLE: begin
                    if (!byte_last_i) begin
                        state_r <= IN_PKT;
                    end
                end
                IN_PKT: begin
                    if (byte_last_i) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    ast_out_fifo2 #(
        .DATA_W  (DATA_W),
        .EMPTY_W (AST_SOURCE_EMPTY_W)
    ) u_out_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (complete_s),
        .push_beat_i   (push_beat_s),
        .pop_ready_i   (ast_source_ready_i),
        .head_beat_o   (head_flat_s),
        .occupancy_o   (occupancy_s),
        .almost_full_o (afull_s)
    );

    assign head_beat_s                = head_flat_s;
    assign byte_ready_o               = ~afull_s;
    assign ast_source_valid_o         = (occupancy_s != 2'd0);
    assign ast_source_data_o          = head_beat_s.data;
    assign ast_source_startofpacket_o = head_beat_s.sop;
    assign ast_source_endofpacket_o   = head_beat_s.eop;
    assign ast_source_empty_o         = head_beat_s.empty;

endmodule : ast_byte_packer

// File: tb/tb_ast_byte_packer.sv
// Directed bench for ast_byte_packer: an 8-symbol big-endian instance and
// a 1-symbol instance, with beats collected at the falling edge.
module tb_ast_byte_packer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-symbol instance
    logic [7:0]  b8_data;
    logic        b8_valid, b8_last, b8_ready;
    logic [63:0] s8_data;
    logic        s8_valid, s8_ready, s8_sop, s8_eop;
    logic [2:0]  s8_empty;

    // 1-symbol instance
    logic [7:0]  b1_data;
    logic        b1_valid, b1_last, b1_ready;
    logic [7:0]  s1_data;
    logic        s1_valid, s1_ready, s1_sop, s1_eop;
    logic [0:0]  s1_empty;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int sym1_drop    = 0;
    logic sym1_active = 1'b0;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat8_t;

    beat8_t      q8[$];
    logic [10:0] q1[$];

    ast_byte_packer #(.AST_SOURCE_SYMBOLS(8), .AST_SOURCE_ORDER(1)) dut8 (
        .clk_i(clk), .rst_i(rst),
        .byte_data_i(b8_data), .byte_valid_i(b8_valid), .byte_last_i(b8_last),
        .byte_ready_o(b8_ready),
        .ast_source_data_o(s8_data), .ast_source_valid_o(s8_valid),
        .ast_source_ready_i(s8_ready),
        .ast_source_startofpacket_o(s8_sop), .ast_source_endofpacket_o(s8_eop),
        .ast_source_empty_o(s8_empty)
    );

    ast_byte_packer #(.AST_SOURCE_SYMBOLS(1), .AST_SOURCE_ORDER(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .byte_data_i(b1_data), .byte_valid_i(b1_valid), .byte_last_i(b1_last),
        .byte_ready_o(b1_ready),
        .ast_source_data_o(s1_data), .ast_source_valid_o(s1_valid),
        .ast_source_ready_i(s1_ready),
        .ast_source_startofpacket_o(s1_sop), .ast_source_endofpacket_o(s1_eop),
        .ast_source_empty_o(s1_empty)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Beat collectors: a beat transfers at the next rising edge.
    always @(negedge clk) begin
        if (!rst && s8_valid && s8_ready) q8.push_back({s8_data, s8_sop, s8_eop, s8_empty});
        if (!rst && s1_valid && s1_ready) q1.push_back({s1_empty, s1_sop, s1_eop, s1_data});
        if (sym1_active && !b1_ready) sym1_drop = sym1_drop + 1;
    end

    task automatic send8(input logic [7:0] d, input logic l);
        int   waited = 0;
        logic acc    = 1'b0;
        b8_data = d; b8_valid = 1'b1; b8_last = l;
        while (!acc && waited < 100) begin
            @(negedge clk); acc = b8_ready;
            @(posedge clk); #1;
            waited++;
        end
        if (!acc) begin
            tests_run++; tests_failed++;
            $display("FAIL send8_timeout byte %h not accepted within %0d cycles", d, waited);
        end
        b8_valid = 1'b0; b8_last = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d, input logic l);
        int   waited = 0;
        logic acc    = 1'b0;
        b1_data = d; b1_valid = 1'b1; b1_last = l;
        while (!acc && waited < 100) begin
            @(negedge clk); acc = b1_ready;
            @(posedge clk); #1;
            waited++;
        end
        if (!acc) begin
            tests_run++; tests_failed++;
            $display("FAIL send1_timeout byte %h not accepted within %0d cycles", d, waited);
        end
        b1_valid = 1'b0; b1_last = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b8_data = 8'h00; b8_valid = 1'b0; b8_last = 1'b0; s8_ready = 1'b0;
        b1_data = 8'h00; b1_valid = 1'b0; b1_last = 1'b0; s1_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({s8_valid, s8_sop, s8_eop, s8_empty, s8_data, b8_ready} !== 71'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs8 got v%b s%b e%b em%h d%h r%b, expected all 0",
                     s8_valid, s8_sop, s8_eop, s8_empty, s8_data, b8_ready);
        end
        tests_run++;
        if ({s1_valid, b1_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_outputs1 got valid %b ready %b, expected 0 0", s1_valid, b1_ready);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        tests_run++;
        if ({b8_ready, b1_ready, s8_valid} !== 3'b110) begin
            tests_failed++;
            $display("FAIL reset_release got ready8 %b ready1 %b valid8 %b, expected 1 1 0",
                     b8_ready, b1_ready, s8_valid);
        end
        @(posedge clk); #1;
        s8_ready = 1'b1; s1_ready = 1'b1;
    endtask

    task automatic test_two_beats();
        q8.delete();
        for (int i = 0; i < 16; i++) send8(8'(i), i == 15);
        drain();
        tests_run++;
        if (q8.size() !== 2) begin
            tests_failed++;
            $display("FAIL two_beats_count got %0d, expected 2", q8.size());
        end
        if (q8.size() >= 2) begin
            tests_run++;
            if (q8[0] !== {64'h0001020304050607, 1'b1, 1'b0, 3'd0}) begin
                tests_failed++;
                $display("FAIL two_beats_b0 got %h, expected %h", q8[0], {64'h0001020304050607, 1'b1, 1'b0, 3'd0});
            end
            tests_run++;
            if (q8[1] !== {64'h08090A0B0C0D0E0F, 1'b0, 1'b1, 3'd0}) begin
                tests_failed++;
                $display("FAIL two_beats_b1 got %h, expected %h", q8[1], {64'h08090A0B0C0D0E0F, 1'b0, 1'b1, 3'd0});
            end
        end
    endtask

    task automatic test_single();
        q8.delete();
        send8(8'hAA, 1'b1);
        drain();
        tests_run++;
        if (q8.size() !== 1) begin
            tests_failed++;
            $display("FAIL single_count got %0d, expected 1", q8.size());
        end
        if (q8.size() >= 1) begin
            tests_run++;
            if ({q8[0].data[63:56], q8[0].sop, q8[0].eop, q8[0].empty} !== {8'hAA, 1'b1, 1'b1, 3'd7}) begin
                tests_failed++;
                $display("FAIL single_beat got sym7 %h sop %b eop %b empty %0d, expected aa 1 1 7",
                         q8[0].data[63:56], q8[0].sop, q8[0].eop, q8[0].empty);
            end
`ifdef AST_BYTE_PACKER_ZERO_PAD_EN
            tests_run++;
            if (q8[0].data[55:0] !== 56'd0) begin
                tests_failed++;
                $display("FAIL single_pad got %h, expected 0", q8[0].data[55:0]);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        q8.delete();
        for (int i = 0; i < 11; i++) send8(8'(8'h10 + i), i == 10);
        for (int i = 0; i < 3; i++)  send8(8'(8'h20 + i), i == 2);
        drain();
        tests_run++;
        if (q8.size() !== 3) begin
            tests_failed++;
            $display("FAIL b2b_count got %0d, expected 3", q8.size());
        end
        if (q8.size() >= 3) begin
            tests_run++;
            if (q8[0] !== {64'h1011121314151617, 1'b1, 1'b0, 3'd0}) begin
                tests_failed++;
                $display("FAIL b2b_b0 got %h, expected %h", q8[0], {64'h1011121314151617, 1'b1, 1'b0, 3'd0});
            end
            tests_run++;
            if ({q8[1].data[63:40], q8[1].sop, q8[1].eop, q8[1].empty} !== {24'h18191A, 1'b0, 1'b1, 3'd5}) begin
                tests_failed++;
                $display("FAIL b2b_b1 got %h %b %b %0d, expected 18191a 0 1 5",
                         q8[1].data[63:40], q8[1].sop, q8[1].eop, q8[1].empty);
            end
            tests_run++;
            if ({q8[2].data[63:40], q8[2].sop, q8[2].eop, q8[2].empty} !== {24'h202122, 1'b1, 1'b1, 3'd5}) begin
                tests_failed++;
                $display("FAIL b2b_b2 got %h %b %b %0d, expected 202122 1 1 5",
                         q8[2].data[63:40], q8[2].sop, q8[2].eop, q8[2].empty);
            end
`ifdef AST_BYTE_PACKER_ZERO_PAD_EN
            tests_run++;
            if ({q8[1].data[39:0], q8[2].data[39:0]} !== 80'd0) begin
                tests_failed++;
                $display("FAIL b2b_pad got %h %h, expected 0", q8[1].data[39:0], q8[2].data[39:0]);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_d;
        q8.delete();
        fork
            begin
                for (int i = 0; i < 32; i++) send8(8'(8'h40 + i), i == 31);
            end
            begin
                s8_ready = 1'b0;
                repeat (19) @(posedge clk);
                @(negedge clk);
                tests_run++;
                if ({b8_ready, s8_valid, s8_sop, s8_data} !== {1'b0, 1'b1, 1'b1, 64'h4041424344454647}) begin
                    tests_failed++;
                    $display("FAIL bp_hold got ready %b valid %b sop %b data %h, expected 0 1 1 4041424344454647",
                             b8_ready, s8_valid, s8_sop, s8_data);
                end
                @(posedge clk); #1;
                s8_ready = 1'b1;
            end
        join
        drain();
        tests_run++;
        if (q8.size() !== 4) begin
            tests_failed++;
            $display("FAIL bp_count got %0d, expected 4", q8.size());
        end
        for (int k = 0; k < 4 && k < q8.size(); k++) begin
            for (int j = 0; j < 8; j++) exp_d[63-8*j -: 8] = 8'(8'h40 + 8*k + j);
            tests_run++;
            if (q8[k] !== {exp_d, k == 0, k == 3, 3'd0}) begin
                tests_failed++;
                $display("FAIL bp_beat%0d got %h, expected %h", k, q8[k], {exp_d, k == 0, k == 3, 3'd0});
            end
        end
    endtask

    task automatic test_sym1();
        logic [7:0] bytes[64];
        int start_cyc;
        q1.delete();
        for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom_range(0, 255));
        start_cyc = cyc;
        sym1_active = 1'b1;
        for (int i = 0; i < 64; i++) send1(bytes[i], i == 63);
        sym1_active = 1'b0;
        tests_run++;
        if (cyc - start_cyc !== 64) begin
            tests_failed++;
            $display("FAIL sym1_rate got %0d cycles, expected 64", cyc - start_cyc);
        end
        tests_run++;
        if (sym1_drop !== 0) begin
            tests_failed++;
            $display("FAIL sym1_ready got %0d low cycles, expected 0", sym1_drop);
        end
        drain();
        tests_run++;
        if (q1.size() !== 64) begin
            tests_failed++;
            $display("FAIL sym1_count got %0d, expected 64", q1.size());
        end
        for (int i = 0; i < 64 && i < q1.size(); i++) begin
            tests_run++;
            if (q1[i] !== {1'b0, i == 0, i == 63, bytes[i]}) begin
                tests_failed++;
                $display("FAIL sym1_beat%0d got %h, expected %h", i, q1[i], {1'b0, i == 0, i == 63, bytes[i]});
            end
        end
    endtask

    task automatic test_reset_mid();
        q8.delete();
        for (int i = 0; i < 5; i++) send8(8'(8'h50 + i), 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (q8.size() !== 0) begin
            tests_failed++;
            $display("FAIL rstmid_partial got %0d beats, expected 0", q8.size());
        end
        for (int i = 0; i < 8; i++) send8(8'(8'h60 + i), i == 7);
        drain();
        tests_run++;
        if (q8.size() !== 1) begin
            tests_failed++;
            $display("FAIL rstmid_count got %0d, expected 1", q8.size());
        end
        if (q8.size() >= 1) begin
            tests_run++;
            if (q8[0] !== {64'h6061626364656667, 1'b1, 1'b1, 3'd0}) begin
                tests_failed++;
                $display("FAIL rstmid_beat got %h, expected %h", q8[0], {64'h6061626364656667, 1'b1, 1'b1, 3'd0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_beats();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_sym1();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule : tb_ast_byte_packer
